// File: rtl/regfile_access_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// regfile_access_ctrl_pkg
// Shared definitions for the register-file access controller:
//   REGFILE_CK_EN_ACTIVE / REGFILE_WR_ACTIVE : active levels of the regfile pins
//   rfa_state_e                              : operand output FSM encoding
//   rf_impl_f(addr)                          : 1 for implemented register numbers
// ----------------------------------------------------------------------------
package regfile_access_ctrl_pkg;

  localparam logic REGFILE_CK_EN_ACTIVE = 1'b1;
  localparam logic REGFILE_WR_ACTIVE    = 1'b1;

  typedef enum logic [1:0] {
    RFA_EMPTY = 2'd0,
    RFA_FRESH = 2'd1,
    RFA_HELD  = 2'd2
  } rfa_state_e;

  // Implemented registers are 0-3, 10-15 and 26-31; everything else is a hole.
  // Callers zero-extend the register number to 32 bits so the check does not
  // depend on the address width of the instantiating block.
  function automatic logic rf_impl_f(input logic [31:0] addr);
    return (addr <= 32'd3) ||
           ((addr >= 32'd10) && (addr <= 32'd15)) ||
           ((addr >= 32'd26) && (addr <= 32'd31));
  endfunction

endpackage

// File: rtl/regfile_access_ctrl_wb_fifo.sv
// ----------------------------------------------------------------------------
// regfile_wb_fifo
// Write-back queue in front of the register-file write port, with two
// associative lookup ports used to bypass queued data into operand reads.
//   clk, rst              : clock, asynchronous active-high reset (flushes)
//   push/push_addr/data   : enqueue one write (caller guarantees !full)
//   pop                   : drain the head (caller guarantees !empty)
//   full, empty           : occupancy flags
//   head_addr/head_data   : oldest entry, presented to the write port
//   lk_addr_x             : lookup register number
//   lk_hit_x/lk_data_x    : youngest valid entry matching lk_addr_x
// ----------------------------------------------------------------------------
module regfile_wb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  input  logic [ADDR_W-1:0] lk_addr_a,
  input  logic [ADDR_W-1:0] lk_addr_b,
  output logic              lk_hit_a,
  output logic              lk_hit_b,
  output logic [DATA_W-1:0] lk_data_a,
  output logic [DATA_W-1:0] lk_data_b
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  idx;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; the extra count bit
  // separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: an entry is only observed while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  // Walk entries oldest to youngest so a later match overrides an earlier
  // one. The head is included even while it is being written this cycle,
  // because the register file only sees that data after the edge.
  always_comb begin
    lk_hit_a  = 1'b0;
    lk_hit_b  = 1'b0;
    lk_data_a = '0;
    lk_data_b = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if (addr_q[idx] == lk_addr_a) begin
          lk_hit_a  = 1'b1;
          lk_data_a = data_q[idx];
        end
        if (addr_q[idx] == lk_addr_b) begin
          lk_hit_b  = 1'b1;
          lk_data_b = data_q[idx];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_access_ctrl
// Requester-side controller for the 2R/1W core register file.
//   clk, rst_a                 : clock, asynchronous active-high reset
//   rd_req_*  / rd_addr_a/b    : operand-read request handshake
//   op_*      / op_data_a/b    : operand response handshake
//   wb_*                       : write-back request handshake
//   wr_hold                    : write port busy, pauses the queue drain
//   addr_err                   : registered pulse, unimplemented register used
//   address_a/b, ck_en_a/b     : regfile read ports (rd_data_a/b come back)
//   address_w, wr_data, we,
//   ck_en_w                    : regfile write port, driven from queue head
// ----------------------------------------------------------------------------
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int WB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_data_a,
  output logic [DATA_W-1:0] op_data_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wr_hold,
  output logic              addr_err,
  output logic [ADDR_W-1:0] address_a,
  output logic [ADDR_W-1:0] address_b,
  output logic              ck_en_a,
  output logic              ck_en_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic [ADDR_W-1:0] address_w,
  output logic [DATA_W-1:0] wr_data,
  output logic              we,
  output logic              ck_en_w
);

  rfa_state_e        state;
  logic [ADDR_W-1:0] lat_a, lat_b;
  logic [DATA_W-1:0] cap_a, cap_b;
  logic [DATA_W-1:0] fresh_a, fresh_b;
  logic              rd_acc, wb_acc, wb_push, drain;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              hit_a, hit_b;
  logic [DATA_W-1:0] byp_a, byp_b;

  // Reads are refused while reset is active so no regfile port toggles then.
  assign rd_req_ready = !rst_a && ((state == RFA_EMPTY) || op_ready);
  assign rd_acc       = rd_req_valid && rd_req_ready;

  assign wb_ready = !fifo_full;
  assign wb_acc   = wb_valid && wb_ready;
  // Write-backs to holes are consumed but never reach the queue.
  assign wb_push  = wb_acc && rf_impl_f(32'(wb_addr));
  assign drain    = !fifo_empty && !wr_hold;

  assign address_a = rst_a ? '0 : rd_addr_a;
  assign address_b = rst_a ? '0 : rd_addr_b;
  assign ck_en_a   = rd_acc ? REGFILE_CK_EN_ACTIVE : !REGFILE_CK_EN_ACTIVE;
  assign ck_en_b   = ck_en_a;

  assign address_w = fifo_empty ? '0 : head_addr;
  assign wr_data   = fifo_empty ? '0 : head_data;
  assign we        = drain ? REGFILE_WR_ACTIVE : !REGFILE_WR_ACTIVE;
  assign ck_en_w   = we;

  regfile_wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WB_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst_a),
    .push      (wb_push),
    .push_addr (wb_addr),
    .push_data (wb_data),
    .pop       (drain),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_addr (head_addr),
    .head_data (head_data),
    .lk_addr_a (lat_a),
    .lk_addr_b (lat_b),
    .lk_hit_a  (hit_a),
    .lk_hit_b  (hit_b),
    .lk_data_a (byp_a),
    .lk_data_b (byp_b)
  );

  // Operands in FRESH: holes read as zero, otherwise the youngest queued
  // write to the latched register wins over the array contents.
  always_comb begin
    fresh_a = rd_data_a;
    fresh_b = rd_data_b;
    if (!rf_impl_f(32'(lat_a))) fresh_a = '0;
    else if (hit_a)             fresh_a = byp_a;
    if (!rf_impl_f(32'(lat_b))) fresh_b = '0;
    else if (hit_b)             fresh_b = byp_b;
  end

  assign op_valid  = (state != RFA_EMPTY);
  assign op_data_a = (state == RFA_HELD) ? cap_a : ((state == RFA_FRESH) ? fresh_a : '0);
  assign op_data_b = (state == RFA_HELD) ? cap_b : ((state == RFA_FRESH) ? fresh_b : '0);

  // Output FSM. A stalled FRESH result is frozen into the capture registers
  // so later queue drains to the same register cannot change it.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state    <= RFA_EMPTY;
      lat_a    <= '0;
      lat_b    <= '0;
      cap_a    <= '0;
      cap_b    <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= (rd_acc && (!rf_impl_f(32'(rd_addr_a)) || !rf_impl_f(32'(rd_addr_b)))) ||
                  (wb_acc && !rf_impl_f(32'(wb_addr)));
      if (rd_acc) begin
        lat_a <= rd_addr_a;
        lat_b <= rd_addr_b;
      end
      case (state)
        RFA_EMPTY: begin
          if (rd_acc) state <= RFA_FRESH;
        end
        RFA_FRESH: begin
          if (op_ready) begin
            state <= rd_acc ? RFA_FRESH : RFA_EMPTY;
          end else begin
            state <= RFA_HELD;
            cap_a <= fresh_a;
            cap_b <= fresh_b;
          end
        end
        RFA_HELD: begin
          if (op_ready) state <= rd_acc ? RFA_FRESH : RFA_EMPTY;
        end
        default: state <= RFA_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_access_ctrl
// Bench for regfile_access_ctrl with a behavioural 2R/1W register file.
// Expected operands are queued when a read is accepted and compared by a
// separate monitor whenever op_valid is high.
// ----------------------------------------------------------------------------
module tb_regfile_access_ctrl;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int WB_DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_a;
  logic              rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
  logic              op_valid, op_ready;
  logic [DATA_W-1:0] op_data_a, op_data_b;
  logic              wb_valid, wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wr_hold, addr_err;
  logic [ADDR_W-1:0] address_a, address_b, address_w;
  logic              ck_en_a, ck_en_b, we, ck_en_w;
  logic [DATA_W-1:0] rd_data_a, rd_data_b, wr_data;

  always #5 clk = ~clk;

  regfile_access_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .WB_DEPTH (WB_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_a        (rst_a),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_data_a    (op_data_a),
    .op_data_b    (op_data_b),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wr_hold      (wr_hold),
    .addr_err     (addr_err),
    .address_a    (address_a),
    .address_b    (address_b),
    .ck_en_a      (ck_en_a),
    .ck_en_b      (ck_en_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .address_w    (address_w),
    .wr_data      (wr_data),
    .we           (we),
    .ck_en_w      (ck_en_w)
  );

  // Behavioural regfile_3p: addresses latched on ck_en, data combinational
  // from the latched address, write on the clock edge.
  logic [DATA_W-1:0] mem [32];
  logic [ADDR_W-1:0] rf_lat_a, rf_lat_b;

  always @(posedge clk) begin
    if (ck_en_a) rf_lat_a <= address_a;
    if (ck_en_b) rf_lat_b <= address_b;
    if (we && ck_en_w) mem[address_w] <= wr_data;
  end
  assign rd_data_a = mem[rf_lat_a];
  assign rd_data_b = mem[rf_lat_b];

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_t;
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  op_t               opq [$];
  wr_t               wq  [$];
  logic [DATA_W-1:0] arch [32];
  bit                exp_valid;
  bit                exp_err;
  int                n_checks = 0;
  int                n_fail   = 0;

  function automatic bit impl_reg(input logic [ADDR_W-1:0] a);
    return (a <= 5'd3) || ((a >= 5'd10) && (a <= 5'd15)) || (a >= 5'd26);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Operand monitor: whatever is presented must equal the oldest expected
  // result; it is retired when the consumer takes it.
  always @(negedge clk) begin
    if (!rst_a && op_valid) begin
      if (opq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_op: got op_valid=1 with a=0x%08h, expected no pending operand", op_data_a);
      end else begin
        checkOutput("op_data_a", op_data_a, opq[0].a);
        checkOutput("op_data_b", op_data_b, opq[0].b);
        if (op_ready) void'(opq.pop_front());
      end
    end
  end

  // One clock of stimulus. Control outputs are checked at mid-cycle against
  // the model state from before this cycle, then the model is advanced.
  task automatic applyStimulus(input bit rv, input logic [ADDR_W-1:0] ra,
                               input logic [ADDR_W-1:0] rb, input bit wv,
                               input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                               input bit hold, input bit ordy);
    bit  racc, wacc;
    op_t o;
    wr_t w;
    rd_req_valid = rv;
    rd_addr_a    = ra;
    rd_addr_b    = rb;
    wb_valid     = wv;
    wb_addr      = wa;
    wb_data      = wd;
    wr_hold      = hold;
    op_ready     = ordy;
    @(negedge clk);
    checkOutput("op_valid", 32'(op_valid), 32'(exp_valid));
    checkOutput("rd_req_ready", 32'(rd_req_ready), 32'(!exp_valid || ordy));
    checkOutput("wb_ready", 32'(wb_ready), 32'(wq.size() < WB_DEPTH));
    checkOutput("addr_err", 32'(addr_err), 32'(exp_err));
    checkOutput("we", 32'(we), 32'((wq.size() > 0) && !hold));
    checkOutput("ck_en_a", 32'(ck_en_a), 32'(rv && (!exp_valid || ordy)));
    if (we && (wq.size() > 0)) begin
      checkOutput("address_w", 32'(address_w), 32'(wq[0].addr));
      checkOutput("wr_data", wr_data, wq[0].data);
      void'(wq.pop_front());
    end
    racc = rv && rd_req_ready;
    wacc = wv && wb_ready;
    if (wacc && impl_reg(wa)) begin
      arch[wa] = wd;
      w.addr   = wa;
      w.data   = wd;
      wq.push_back(w);
    end
    if (racc) begin
      checkOutput("address_a", 32'(address_a), 32'(ra));
      checkOutput("address_b", 32'(address_b), 32'(rb));
      o.a = impl_reg(ra) ? arch[ra] : '0;
      o.b = impl_reg(rb) ? arch[rb] : '0;
      opq.push_back(o);
    end
    exp_err   = (racc && (!impl_reg(ra) || !impl_reg(rb))) || (wacc && !impl_reg(wa));
    exp_valid = racc || (exp_valid && !ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    rf_lat_a = '0;
    rf_lat_b = '0;
    // Reset with a live read request and a nonzero address on the pins.
    rst_a = 1'b1;
    rd_req_valid = 1'b1; rd_addr_a = 5'd7; rd_addr_b = 5'd12;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wr_hold = 1'b0; op_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_op_valid", 32'(op_valid), 32'd0);
    checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
    checkOutput("rst_ck_en_a", 32'(ck_en_a), 32'd0);
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_address_a", 32'(address_a), 32'd0);
    checkOutput("rst_address_w", 32'(address_w), 32'd0);
    checkOutput("rst_wr_data", wr_data, 32'd0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rd_req_valid = 1'b0;
    for (int i = 0; i < 32; i++) arch[i] = mem[i];
    exp_valid = 1'b0;
    exp_err   = 1'b0;

    $display("[TB] write-back then read through the queue");
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd12, 32'hA5A5_0001, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd12, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    idle(2);

    $display("[TB] stalled write port, youngest entry wins");
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 32'h11, 1'b1, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 32'h22, 1'b1, 1'b1);
    applyStimulus(1'b1, 5'd2, 5'd13, 1'b1, 5'd2, 32'h33, 1'b1, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    idle(3);

    $display("[TB] held operand stays stable across a drain");
    applyStimulus(1'b1, 5'd30, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd30, 32'hDEAD, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd30, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    idle(2);

    $display("[TB] back-to-back reads");
    applyStimulus(1'b1, 5'd10, 5'd1, 1'b1, 5'd10, 32'h55, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd10, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd13, 5'd26, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd31, 5'd12, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd30, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    idle(2);

    $display("[TB] unimplemented registers");
    applyStimulus(1'b1, 5'd5, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    idle(1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd20, 32'h7, 1'b0, 1'b1);
    idle(1);
    applyStimulus(1'b1, 5'd1, 5'd20, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    idle(2);

    $display("[TB] asynchronous reset with queued writes");
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd14, 32'hBEEF_0014, 1'b1, 1'b1);
    applyStimulus(1'b1, 5'd14, 5'd11, 1'b1, 5'd11, 32'hBEEF_0011, 1'b1, 1'b0);
    #3;
    wr_hold = 1'b0;
    rd_req_valid = 1'b0;
    wb_valid = 1'b0;
    rst_a = 1'b1;
    #1;
    checkOutput("async_op_valid", 32'(op_valid), 32'd0);
    checkOutput("async_we", 32'(we), 32'd0);
    checkOutput("async_wb_ready", 32'(wb_ready), 32'd1);
    opq.delete();
    wq.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    for (int i = 0; i < 32; i++) arch[i] = mem[i];
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    applyStimulus(1'b1, 5'd14, 5'd11, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    idle(3);

    checkOutput("op_queue_drained", 32'(opq.size()), 32'd0);
    checkOutput("wr_queue_drained", 32'(wq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
